// File: rtl/conv_ctrl_fsm_if.sv
// Command/status bundle between the micro GPIO side and the convolution controller.
// The controller takes the slave modport; the command source takes master.
interface conv_ctrl_fsm_if #(
  parameter int NB_ADDRESS = 10,
  parameter int NB_BLK     = 8
);
  logic                  i_start;
  logic                  i_next;
  logic                  i_ki;
  logic [NB_ADDRESS-1:0] i_last_addr;
  logic [NB_BLK-1:0]     i_nblk;
  logic                  o_sop;
  logic                  o_eop;
  logic                  o_chblk;
  logic                  o_valid;
  logic                  o_ki;
  logic [NB_ADDRESS-1:0] o_RAddr;
  logic [NB_ADDRESS-1:0] o_WAddr;
  logic                  o_wvalid;
  logic [NB_BLK-1:0]     o_blk_cnt;
  logic                  o_done;

  modport master (
    output i_start, i_next, i_ki, i_last_addr, i_nblk,
    input  o_sop, o_eop, o_chblk, o_valid, o_ki, o_RAddr, o_WAddr,
           o_wvalid, o_blk_cnt, o_done
  );

  modport slave (
    input  i_start, i_next, i_ki, i_last_addr, i_nblk,
    output o_sop, o_eop, o_chblk, o_valid, o_ki, o_RAddr, o_WAddr,
           o_wvalid, o_blk_cnt, o_done
  );
endinterface

// File: rtl/conv_ctrl_fsm.sv
// Block-sequencing controller for the convolver: streams read addresses per block,
// tracks write-back addresses LATENCY cycles behind, and steps blocks on micro commands.
module conv_ctrl_fsm #(
  parameter int NB_ADDRESS = 10,
  parameter int LATENCY    = 3,
  parameter int NB_BLK     = 8
) (
  input  logic          CLK100MHZ,
  input  logic          rst,
  conv_ctrl_fsm_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RUN       = 3'd1;
  localparam logic [2:0] FLUSH     = 3'd2;
  localparam logic [2:0] WAIT_NEXT = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam int           NB_LAT  = $clog2(LATENCY + 2);
  localparam logic [NB_LAT-1:0] LAT_MAX = NB_LAT'(LATENCY);

  logic [2:0]            state_q, state_d;
  logic                  start_prev_q, next_prev_q;
  logic                  ki_q, ki_d;
  logic [NB_ADDRESS-1:0] last_q, last_d;
  logic [NB_BLK-1:0]     nblk_m1_q, nblk_m1_d;
  logic [NB_BLK-1:0]     blk_q, blk_d;
  logic [NB_ADDRESS-1:0] rd_q, rd_d;
  logic [NB_ADDRESS-1:0] wr_q, wr_d;
  logic [NB_LAT-1:0]     lat_q, lat_d;
  logic                  chblk_q, chblk_d;

  logic start_edge, next_edge, in_blk, wvalid, wr_last;

  assign start_edge = bus.i_start & ~start_prev_q;
  assign next_edge  = bus.i_next & ~next_prev_q;
  assign in_blk     = (state_q == RUN) || (state_q == FLUSH);
  // Write-back trails the read stream by exactly LATENCY block cycles.
  assign wvalid     = in_blk && (lat_q == LAT_MAX);
  assign wr_last    = wvalid && (wr_q == last_q);

  always_comb begin
    state_d   = state_q;
    ki_d      = ki_q;
    last_d    = last_q;
    nblk_m1_d = nblk_m1_q;
    blk_d     = blk_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    lat_d     = lat_q;
    chblk_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d   = RUN;
          ki_d      = bus.i_ki;
          last_d    = bus.i_last_addr;
          nblk_m1_d = (bus.i_nblk == '0) ? '0 : bus.i_nblk - NB_BLK'(1);
          blk_d     = '0;
          rd_d      = '0;
          wr_d      = '0;
          lat_d     = '0;
        end
      end
      RUN, FLUSH: begin
        if (state_q == RUN) begin
          if (rd_q == last_q) state_d = FLUSH;
          else                rd_d    = rd_q + NB_ADDRESS'(1);
        end
        // Counters saturate at the last address so an all-ones height never wraps.
        if (!wvalid)       lat_d = lat_q + NB_LAT'(1);
        else if (!wr_last) wr_d  = wr_q + NB_ADDRESS'(1);
        if (wr_last) begin
          if (blk_q == nblk_m1_q) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_NEXT;
            chblk_d = 1'b1;
          end
        end
      end
      WAIT_NEXT: begin
        if (next_edge) begin
          state_d = RUN;
          blk_d   = blk_q + NB_BLK'(1);
          rd_d    = '0;
          wr_d    = '0;
          lat_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b1;
      next_prev_q  <= 1'b1;
      ki_q         <= 1'b0;
      last_q       <= '0;
      nblk_m1_q    <= '0;
      blk_q        <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      lat_q        <= '0;
      chblk_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= bus.i_start;
      next_prev_q  <= bus.i_next;
      ki_q         <= ki_d;
      last_q       <= last_d;
      nblk_m1_q    <= nblk_m1_d;
      blk_q        <= blk_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      lat_q        <= lat_d;
      chblk_q      <= chblk_d;
    end
  end

  assign bus.o_sop     = in_blk;
  assign bus.o_eop     = (state_q == IDLE) || (state_q == WAIT_NEXT) || (state_q == DONE);
  assign bus.o_chblk   = chblk_q;
  assign bus.o_valid   = (state_q == RUN);
  assign bus.o_ki      = ki_q;
  assign bus.o_RAddr   = rd_q;
  assign bus.o_WAddr   = wr_q;
  assign bus.o_wvalid  = wvalid;
  assign bus.o_blk_cnt = blk_q;
  assign bus.o_done    = (state_q == DONE);

endmodule

// File: tb/tb_conv_ctrl_fsm.sv
// Scoreboard bench for conv_ctrl_fsm: frames are described by address/cycle rules,
// pushed on each command, and matched by a monitor against every DUT output event.
module tb_conv_ctrl_fsm;
  localparam int NB_ADDRESS = 10;
  localparam int LATENCY    = 3;
  localparam int NB_BLK     = 8;

  logic CLK100MHZ = 1'b0;
  logic rst       = 1'b1;
  always #5 CLK100MHZ = ~CLK100MHZ;

  conv_ctrl_fsm_if #(.NB_ADDRESS(NB_ADDRESS), .NB_BLK(NB_BLK)) bus();

  conv_ctrl_fsm #(.NB_ADDRESS(NB_ADDRESS), .LATENCY(LATENCY), .NB_BLK(NB_BLK)) dut (
    .CLK100MHZ(CLK100MHZ),
    .rst      (rst),
    .bus      (bus)
  );

  typedef struct {int addr; int rel; int blk; int ki;} exp_t;
  typedef struct {int kind; int rel;} ev_t;   // kind 1 = chblk, 2 = done

  exp_t rdq[$];
  exp_t wrq[$];
  ev_t  evq[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int cyc = 0;
  bit sop_prev = 1'b0;
  int blk_start = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: read k at block cycle k, write a at cycle a+LATENCY, end marker right after.
  task automatic push_block(input int last, input int b, input int ki, input bit final_blk);
    exp_t e;
    ev_t  v;
    for (int k = 0; k <= last; k++) begin
      e.addr = k; e.rel = k; e.blk = b; e.ki = ki;
      rdq.push_back(e);
    end
    for (int a = 0; a <= last; a++) begin
      e.addr = a; e.rel = a + LATENCY; e.blk = b; e.ki = ki;
      wrq.push_back(e);
    end
    v.kind = final_blk ? 2 : 1;
    v.rel  = last + 1 + LATENCY;
    evq.push_back(v);
  endtask

  initial begin : monitor
    exp_t e;
    ev_t  v;
    int   rel;
    forever begin
      @(negedge CLK100MHZ);
      cyc++;
      if (mon_en) begin
        if (bus.o_sop && !sop_prev) blk_start = cyc;
        sop_prev = bus.o_sop;
        rel = cyc - blk_start;
        if (bus.o_valid) begin
          chk("rdq_avail", (rdq.size() > 0) ? 1 : 0, 1);
          if (rdq.size() > 0) begin
            e = rdq.pop_front();
            chk("raddr", int'(bus.o_RAddr), e.addr);
            chk("rd_cycle", rel, e.rel);
            chk("rd_blk_cnt", int'(bus.o_blk_cnt), e.blk);
            chk("ki", int'(bus.o_ki), e.ki);
          end
        end
        if (bus.o_wvalid) begin
          chk("wrq_avail", (wrq.size() > 0) ? 1 : 0, 1);
          if (wrq.size() > 0) begin
            e = wrq.pop_front();
            chk("waddr", int'(bus.o_WAddr), e.addr);
            chk("wr_cycle", rel, e.rel);
            chk("wr_blk_cnt", int'(bus.o_blk_cnt), e.blk);
          end
        end
        if (bus.o_chblk || bus.o_done) begin
          chk("evq_avail", (evq.size() > 0) ? 1 : 0, 1);
          if (evq.size() > 0) begin
            v = evq.pop_front();
            chk("evt_kind", bus.o_done ? 2 : 1, v.kind);
            chk("evt_cycle", rel, v.rel);
            chk("evt_eop", int'(bus.o_eop), 1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic pulse_next(input bit with_start);
    tick();
    bus.i_next = 1'b1;
    if (with_start) bus.i_start = 1'b1;
    tick();
    bus.i_next  = 1'b0;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_evt(output int kind);
    kind = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK100MHZ);
      if (bus.o_done)  begin kind = 2; break; end
      if (bus.o_chblk) begin kind = 1; break; end
    end
    if (kind == 0) chk("evt_timeout", kind, 1);
  endtask

  task automatic run_frame(input int last, input int nblk, input bit spur);
    int eff;
    int ki;
    int kind;
    eff = (nblk == 0) ? 1 : nblk;
    ki  = int'($urandom_range(0, 1));
    bus.i_last_addr = NB_ADDRESS'(last);
    bus.i_nblk      = NB_BLK'(nblk);
    bus.i_ki        = ki[0];
    push_block(last, 0, ki, eff == 1);
    pulse_start();
    // Frame parameters are latched at start; later changes must not matter.
    bus.i_last_addr = NB_ADDRESS'($urandom);
    bus.i_nblk      = NB_BLK'($urandom);
    bus.i_ki        = ~bus.i_ki;
    if (spur && last >= 8) begin
      repeat (2) tick();
      pulse_start();
    end
    for (int b = 0; b < eff; b++) begin
      wait_evt(kind);
      chk("block_end", kind, (b == eff - 1) ? 2 : 1);
      if (kind == 0) return;
      if (b < eff - 1) begin
        repeat ($urandom_range(0, 4)) tick();
        push_block(last, b + 1, ki, (b + 1) == (eff - 1));
        pulse_next(1'($urandom_range(0, 1)));
      end
    end
    repeat (2) tick();
    chk("rdq_drained", rdq.size(), 0);
    chk("wrq_drained", wrq.size(), 0);
    chk("evq_drained", evq.size(), 0);
    chk("idle_eop", int'(bus.o_eop), 1);
    $display("frame last_addr=%0d nblk=%0d ki=%0d spur=%0d checks=%0d", last, nblk, ki, spur, checks);
    // A next command while idle must not start anything.
    pulse_next(1'b0);
    repeat (3) tick();
    chk("idle_next_sop", int'(bus.o_sop), 0);
  endtask

  initial begin : stim
    int  kind;
    bit  found;
    bit  pulse_seen;
    bus.i_start     = 1'b1;
    bus.i_next      = 1'b0;
    bus.i_ki        = 1'b0;
    bus.i_last_addr = '0;
    bus.i_nblk      = '0;

    // Reset values, with start held high across reset release.
    repeat (3) @(negedge CLK100MHZ);
    chk("rst_eop", int'(bus.o_eop), 1);
    chk("rst_sop", int'(bus.o_sop), 0);
    chk("rst_valid", int'(bus.o_valid), 0);
    chk("rst_raddr", int'(bus.o_RAddr), 0);
    chk("rst_blk", int'(bus.o_blk_cnt), 0);
    chk("rst_done", int'(bus.o_done), 0);
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (5) tick();
    chk("held_start_sop", int'(bus.o_sop), 0);
    chk("held_start_eop", int'(bus.o_eop), 1);
    bus.i_last_addr = NB_ADDRESS'(7);
    bus.i_nblk      = NB_BLK'(1);
    bus.i_start     = 1'b0;
    tick();
    push_block(7, 0, 0, 1'b1);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    wait_evt(kind);
    chk("held_start_done", kind, 2);
    repeat (2) tick();
    $display("frame reset-hold last_addr=7 nblk=1 checks=%0d", checks);

    // Directed frames, then randomized ones.
    run_frame(7, 1, 1'b1);
    run_frame(7, 2, 1'b0);
    run_frame(0, 1, 1'b0);
    run_frame(0, 0, 1'b0);
    run_frame(1023, 1, 1'b1);
    for (int f = 0; f < 20; f++)
      run_frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // Reset in the middle of a run aborts the frame silently.
    mon_en          = 1'b0;
    bus.i_last_addr = NB_ADDRESS'(7);
    bus.i_nblk      = NB_BLK'(2);
    bus.i_ki        = 1'b1;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK100MHZ);
      if (bus.o_valid && bus.o_RAddr == NB_ADDRESS'(4)) begin found = 1'b1; break; end
    end
    chk("midrst_reached", int'(found), 1);
    rst = 1'b1;
    @(negedge CLK100MHZ);
    chk("midrst_sop", int'(bus.o_sop), 0);
    chk("midrst_eop", int'(bus.o_eop), 1);
    chk("midrst_valid", int'(bus.o_valid), 0);
    chk("midrst_wvalid", int'(bus.o_wvalid), 0);
    chk("midrst_raddr", int'(bus.o_RAddr), 0);
    chk("midrst_waddr", int'(bus.o_WAddr), 0);
    chk("midrst_ki", int'(bus.o_ki), 0);
    chk("midrst_done", int'(bus.o_done), 0);
    rst = 1'b0;
    pulse_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK100MHZ);
      if (bus.o_done || bus.o_chblk || bus.o_sop) pulse_seen = 1'b1;
    end
    chk("midrst_quiet", int'(pulse_seen), 0);
    $display("frame mid-run reset checks=%0d", checks);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_ctrl_fsm.md
CONV_CTRL_FSM -- requirements
Module: conv_ctrl_fsm

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NB_ADDRESS, 10, memory address width.
- LATENCY, 3, cycles from read address issued to convolver result ready for write-back.
- NB_BLK, 8, block-counter width.

REQ-002 Ports, one per line: name, direction, width, meaning.
- CLK100MHZ, in, 1, clock, rising edge.
- rst, in, 1, reset; synchronous, active-high.
- i_start, in, 1, start command level from micro GPIO; rising edge is significant.
- i_next, in, 1, next-block command level from micro GPIO; rising edge is significant.
- i_ki, in, 1, kernel(1)/image(0) select; sampled at start.
- i_last_addr, in, NB_ADDRESS, last row address of a block (height-1).
- i_nblk, in, NB_BLK, blocks per frame; 0 is treated as 1.
- o_sop, out, 1, run in progress (RUN/FLUSH).
- o_eop, out, 1, block ended; waiting or idle.
- o_chblk, out, 1, one-cycle pulse at end of each non-final block.
- o_valid, out, 1, convolver input valid.
- o_ki, out, 1, latched kernel/image select.
- o_RAddr, out, NB_ADDRESS, memory read address.
- o_WAddr, out, NB_ADDRESS, memory write-back address.
- o_wvalid, out, 1, o_WAddr carries a valid result this cycle.
- o_blk_cnt, out, NB_BLK, current block index.
- o_done, out, 1, one-cycle pulse at end of frame.

Function
REQ-003 Rising-edge detection SHALL use the signal registered one cycle (edge = sig & ~prev); prev registers SHALL reset to 1, so a level held high through reset does not trigger.
REQ-004 States SHALL be IDLE, RUN, FLUSH, WAIT_NEXT, DONE.
REQ-005 IDLE: o_eop=1, o_valid=0; a start edge SHALL go to RUN, latch i_ki into o_ki, clear o_blk_cnt, the read counter and the write counter.
REQ-006 RUN, cycle k (k=0 on the first RUN cycle): o_RAddr=k, o_valid=1, o_sop=1, o_eop=0.
REQ-007 RUN exit: when o_RAddr==i_last_addr, the next state SHALL be FLUSH and o_RAddr SHALL hold its value.
REQ-008 Write-back in RUN and FLUSH: o_wvalid=1 and o_WAddr=k-LATENCY when k>=LATENCY; otherwise o_wvalid=0 and o_WAddr=0.
REQ-009 FLUSH: o_valid=0, o_sop=1; the write counter keeps advancing.
REQ-010 FLUSH exit: in the cycle o_WAddr==i_last_addr with o_wvalid=1, the next state SHALL be DONE if o_blk_cnt==max(i_nblk,1)-1; otherwise WAIT_NEXT, with o_chblk=1 for exactly the first WAIT_NEXT cycle.
REQ-011 Block length: one block SHALL occupy exactly i_last_addr+1+LATENCY cycles in RUN+FLUSH.
REQ-012 WAIT_NEXT: o_eop=1, o_sop=0, o_valid=0, o_wvalid=0, addresses held.
REQ-013 WAIT_NEXT exit: a next edge SHALL increment o_blk_cnt, zero both counters, and enter RUN.
REQ-014 DONE SHALL last one cycle with o_done=1 and o_eop=1, then go to IDLE.
REQ-015 A start edge outside IDLE and a next edge outside WAIT_NEXT SHALL be ignored; when both edges occur in the same cycle, only the one valid for the current state acts.
REQ-016 i_last_addr and i_nblk SHALL be sampled at start and held constant for the whole frame.
REQ-017 Counters SHALL be NB_ADDRESS wide; i_last_addr={NB_ADDRESS{1}} SHALL complete with no wrap into a second pass.

Reset
REQ-018 On rst: state=IDLE, o_eop=1, all other outputs 0, counters 0, o_ki=0, prev registers 1.
REQ-019 rst asserted mid-RUN SHALL abort the frame with no o_done or o_chblk pulse.

Verification
REQ-020 Single block (LATENCY=3, last_addr=7, nblk=1): start edge -> RAddr 0..7 over 8 cycles, wvalid for WAddr 0..7 starting at k=3, 11 cycles in RUN+FLUSH, then o_done pulse, then IDLE.
REQ-021 Two blocks (nblk=2): chblk pulse after block 0; no activity until next edge; after next edge, blk_cnt=1 and the block repeats identically, ending with done.
REQ-022 Spurious commands: next edge in IDLE, start edge during RUN -> no state change and no address disturbance.
REQ-023 Reset hold: start held high through rst deassertion -> remains in IDLE; a low-then-high on start -> run begins.
REQ-024 Mid-run reset: rst at RAddr=4 -> next cycle all outputs at reset values, eop=1, no done.
REQ-025 Boundary: last_addr=0 -> one valid cycle and one wvalid at WAddr 0, LATENCY cycles after it; last_addr=1023 -> 1027 cycles, no wrap.
